// File: rtl/transpose_writer_if.sv
// Bundle of the column stream and the memory row-write port seen by
// transpose_writer. The slave modport is the writer's own view; the master
// modport is the surrounding logic (column producer plus memory).
interface transpose_writer_if #(
  parameter int SIZE        = 4,
  parameter int PIXEL_WIDTH = 1
);

  logic [SIZE*PIXEL_WIDTH-1:0] col_pixels;
  logic                        col_valid;
  logic                        col_ready;
  logic [SIZE-1:0]             lane_mask;
  logic [SIZE*PIXEL_WIDTH-1:0] mem_data;
  logic [SIZE-1:0]             mem_valid;
  logic                        mem_req;
  logic                        mem_ack;

  modport slave (
    input  col_pixels, col_valid, lane_mask, mem_ack,
    output col_ready, mem_data, mem_valid, mem_req
  );

  modport master (
    output col_pixels, col_valid, lane_mask, mem_ack,
    input  col_ready, mem_data, mem_valid, mem_req
  );

endinterface

// File: rtl/transpose_writer.sv
// transpose_writer: collects SIZE columns into one of two ping-pong banks,
// then replays the bank one row per memory beat, scattering the row pixels
// onto the lanes picked by lane_mask (k-th set lane gets row pixel k).
// Optional macro TRANSPOSE_WRITER_FLUSH_EN adds a flush input that closes a
// partially filled bank; columns beyond the stored count read back as 0.
module transpose_writer #(
  parameter int SIZE        = 4,
  parameter int PIXEL_WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef TRANSPOSE_WRITER_FLUSH_EN
  input  logic               flush,
`endif
  transpose_writer_if.slave  bus
);

  localparam int              PW   = PIXEL_WIDTH;
  localparam int              CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

  // tb_mem[bank][row][col]; contents are deliberately left unreset
  logic [PW-1:0]      tb_mem [2][SIZE][SIZE];

  logic               wr_bank;
  logic [CW-1:0]      wr_col;
  logic               rd_bank;
  logic [CW-1:0]      rd_row;
  logic [1:0]         full;

  logic               accept;
  logic               close_bank;
  logic               beat_done;
  logic [SIZE*PW-1:0] row_word;

`ifdef TRANSPOSE_WRITER_FLUSH_EN
  logic [CW:0]        col_cnt [2];
  logic [CW:0]        col_count_next;
`endif

  assign bus.col_ready = ~full[wr_bank];
  assign bus.mem_req   = full[rd_bank];
  assign bus.mem_valid = bus.lane_mask & {SIZE{bus.mem_req}};
  assign accept        = bus.col_valid & bus.col_ready;
  assign beat_done     = bus.mem_req & bus.mem_ack;

`ifdef TRANSPOSE_WRITER_FLUSH_EN
  // a flush on the same edge as an accept counts that column before closing
  assign col_count_next = {1'b0, wr_col} + (CW+1)'(accept);
  assign close_bank     = (accept && (wr_col == LAST)) ||
                          (flush && (col_count_next != '0));
`else
  assign close_bank     = accept && (wr_col == LAST);
`endif

  // column write into the bank being filled
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int r = 0; r < SIZE; r++) begin
        tb_mem[wr_bank][r][wr_col] <= bus.col_pixels[r*PW +: PW];
      end
    end
  end

  // bank/row bookkeeping; write close and read free touch different banks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_col  <= '0;
      rd_bank <= 1'b0;
      rd_row  <= '0;
      full    <= '0;
`ifdef TRANSPOSE_WRITER_FLUSH_EN
      col_cnt[0] <= '0;
      col_cnt[1] <= '0;
`endif
    end else begin
      if (close_bank) begin
        wr_col        <= '0;
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
`ifdef TRANSPOSE_WRITER_FLUSH_EN
        col_cnt[wr_bank] <= col_count_next;
`endif
      end else if (accept) begin
        wr_col <= wr_col + 1'b1;
      end

      if (beat_done) begin
        if (rd_row == LAST) begin
          rd_row        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  // current row of the read bank, with unwritten (flushed-off) columns as 0
  always_comb begin
    row_word = '0;
    for (int c = 0; c < SIZE; c++) begin
`ifdef TRANSPOSE_WRITER_FLUSH_EN
      if (c < int'(col_cnt[rd_bank]))
`endif
        row_word[c*PW +: PW] = tb_mem[rd_bank][rd_row][c];
    end
  end

  // lane expansion: the k-th set lane of lane_mask carries row pixel k
  always_comb begin
    int k;
    bus.mem_data = '0;
    k = 0;
    for (int l = 0; l < SIZE; l++) begin
      if (bus.lane_mask[l]) begin
        bus.mem_data[l*PW +: PW] = row_word[k*PW +: PW];
        k = k + 1;
      end
    end
    if (!bus.mem_req) begin
      bus.mem_data = '0;
    end
  end

endmodule

// File: tb/tb_transpose_writer.sv
// Directed bench for transpose_writer with SIZE=4, PIXEL_WIDTH=1.
// Inputs change on the falling edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_transpose_writer;

  logic clk;
  logic rst_n;
`ifdef TRANSPOSE_WRITER_FLUSH_EN
  logic flush;
`endif
  int   vectors;
  int   miscompares;

  transpose_writer_if #(.SIZE(4), .PIXEL_WIDTH(1)) bus ();

  transpose_writer #(.SIZE(4), .PIXEL_WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef TRANSPOSE_WRITER_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_col(input logic [3:0] v);
    bus.col_valid  = 1'b1;
    bus.col_pixels = v;
    tick();
    bus.col_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.lane_mask = 4'hF;
    bus.mem_ack   = 1'b1;
    tick();
    #1;
    vectors++; if (bus.col_ready !== 1'b1) begin miscompares++; $display("FAIL reset_col_ready got %b want 1", bus.col_ready); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    vectors++; if (bus.mem_data !== 4'h0) begin miscompares++; $display("FAIL reset_mem_data got %h want 0", bus.mem_data); end
    vectors++; if (bus.mem_valid !== 4'h0) begin miscompares++; $display("FAIL reset_mem_valid got %h want 0", bus.mem_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] cols [4];
    logic [3:0] rows [4];
    cols = '{4'h1, 4'h2, 4'h4, 4'h8};
    rows = '{4'h1, 4'h2, 4'h4, 4'h8};
    bus.mem_ack = 1'b1;
    bus.lane_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.col_valid = 1'b1; bus.col_pixels = cols[i];
      #1;
      vectors++; if (bus.col_ready !== 1'b1) begin miscompares++; $display("FAIL basic_fill_ready col %0d got %b want 1", i, bus.col_ready); end
      vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL basic_early_req col %0d got %b want 0", i, bus.mem_req); end
      tick();
    end
    bus.col_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL basic_req row %0d got %b want 1", r, bus.mem_req); end
      vectors++; if (bus.mem_data !== rows[r]) begin miscompares++; $display("FAIL basic_data row %0d got %h want %h", r, bus.mem_data, rows[r]); end
      vectors++; if (bus.mem_valid !== 4'hF) begin miscompares++; $display("FAIL basic_valid row %0d got %h want f", r, bus.mem_valid); end
      tick();
    end
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL basic_req_drop got %b want 0", bus.mem_req); end
  endtask

  task automatic test_mask();
    logic [3:0] cols  [4];
    logic [3:0] masks [4];
    logic [3:0] datas [4];
    cols  = '{4'h1, 4'h3, 4'h4, 4'h8};
    masks = '{4'hA, 4'h0, 4'hF, 4'h8};
    datas = '{4'hA, 4'h0, 4'h4, 4'h0};
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) push_col(cols[i]);
    for (int r = 0; r < 4; r++) begin
      bus.lane_mask = masks[r];
      #1;
      vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL mask_req row %0d got %b want 1", r, bus.mem_req); end
      vectors++; if (bus.mem_data !== datas[r]) begin miscompares++; $display("FAIL mask_data row %0d got %h want %h", r, bus.mem_data, datas[r]); end
      vectors++; if (bus.mem_valid !== masks[r]) begin miscompares++; $display("FAIL mask_valid row %0d got %h want %h", r, bus.mem_valid, masks[r]); end
      tick();
    end
    bus.lane_mask = 4'hF;
    #1;
    vectors++; if (bus.mem_valid !== 4'h0) begin miscompares++; $display("FAIL mask_idle_valid got %h want 0", bus.mem_valid); end
    vectors++; if (bus.mem_data !== 4'h0) begin miscompares++; $display("FAIL mask_idle_data got %h want 0", bus.mem_data); end
  endtask

  task automatic test_backpressure();
    logic [3:0] cols [8];
    logic [3:0] rows [8];
    cols = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'hF, 4'h0};
    rows = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h5, 4'h5, 4'h5};
    bus.mem_ack = 1'b0;
    bus.lane_mask = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.col_valid = 1'b1; bus.col_pixels = cols[i];
      #1;
      vectors++; if (bus.col_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready col %0d got %b want 1", i, bus.col_ready); end
      tick();
    end
    bus.col_valid = 1'b1; bus.col_pixels = 4'h6;
    #1;
    vectors++; if (bus.col_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b want 0", bus.col_ready); end
    tick();
    #1;
    vectors++; if (bus.col_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready_hold got %b want 0", bus.col_ready); end
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL bp_req got %b want 1", bus.mem_req); end
    bus.col_valid = 1'b0;
    tick();
    #1;
    vectors++; if (bus.mem_data !== 4'h1) begin miscompares++; $display("FAIL bp_noack_hold got %h want 1", bus.mem_data); end
    bus.mem_ack = 1'b1;
    for (int r = 0; r < 8; r++) begin
      #1;
      vectors++; if (bus.mem_data !== rows[r]) begin miscompares++; $display("FAIL bp_data row %0d got %h want %h", r, bus.mem_data, rows[r]); end
      vectors++; if (bus.col_ready !== (r >= 4)) begin miscompares++; $display("FAIL bp_ready_release row %0d got %b want %b", r, bus.col_ready, (r >= 4)); end
      tick();
    end
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_drop got %b want 0", bus.mem_req); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cols [12];
    logic [3:0] rows [12];
    cols = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1};
    rows = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
    bus.mem_ack = 1'b1;
    bus.lane_mask = 4'hF;
    for (int i = 0; i < 16; i++) begin
      bus.col_valid  = (i < 12);
      bus.col_pixels = (i < 12) ? cols[i] : 4'h0;
      #1;
      if (i < 12) begin
        vectors++; if (bus.col_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready cyc %0d got %b want 1", i, bus.col_ready); end
      end
      vectors++; if (bus.mem_req !== (i >= 4)) begin miscompares++; $display("FAIL b2b_req cyc %0d got %b want %b", i, bus.mem_req, (i >= 4)); end
      if (i >= 4) begin
        vectors++; if (bus.mem_data !== rows[i-4]) begin miscompares++; $display("FAIL b2b_data cyc %0d got %h want %h", i, bus.mem_data, rows[i-4]); end
      end
      tick();
    end
    bus.col_valid = 1'b0;
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req_drop got %b want 0", bus.mem_req); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] cols [4];
    cols = '{4'h8, 4'h4, 4'h2, 4'h1};
    bus.mem_ack = 1'b0;
    bus.lane_mask = 4'hF;
    for (int i = 0; i < 6; i++) push_col(4'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.col_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", bus.col_ready); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req got %b want 0", bus.mem_req); end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.col_valid = 1'b1; bus.col_pixels = cols[i];
      #1;
      vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_early_req col %0d got %b want 0", i, bus.mem_req); end
      tick();
    end
    bus.col_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      vectors++; if (bus.mem_data !== cols[r]) begin miscompares++; $display("FAIL rstmid_data row %0d got %h want %h", r, bus.mem_data, cols[r]); end
      tick();
    end
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_drop got %b want 0", bus.mem_req); end
  endtask

`ifdef TRANSPOSE_WRITER_FLUSH_EN
  task automatic test_flush();
    bus.mem_ack = 1'b1;
    bus.lane_mask = 4'hF;
    push_col(4'hF);
    push_col(4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL flush_req row %0d got %b want 1", r, bus.mem_req); end
      vectors++; if (bus.mem_data !== 4'h3) begin miscompares++; $display("FAIL flush_data row %0d got %h want 3", r, bus.mem_data); end
      tick();
    end
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL flush_req_drop got %b want 0", bus.mem_req); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.col_valid  = 1'b0;
    bus.col_pixels = 4'h0;
    bus.lane_mask  = 4'hF;
    bus.mem_ack    = 1'b0;
`ifdef TRANSPOSE_WRITER_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk);
    tick();
    test_reset();
    test_basic();
    test_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef TRANSPOSE_WRITER_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transpose_writer.md
Name: transpose_writer

Overview:
- Inverse of the memory-to-column transpose path: accepts column vectors of pixels and transposes them back into rows in a ping-pong buffer.
- Emits one row per memory beat, scattered onto memory lanes selected by a lane mask (expansion, the inverse of valid-lane compaction).
- Sits between the compute column stream and the memory write port.

Parameters:
- SIZE, 4, pixels per column = columns per bank = memory lanes
- PIXEL_WIDTH, 1, bits per pixel

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- col_pixels  input  SIZE*PIXEL_WIDTH  column; pixel r is in slice r
- col_valid  input  1  column present
- col_ready  output  1  writer can accept a column
- lane_mask  input  SIZE  memory lanes to be written for the current row beat
- mem_data  output  SIZE*PIXEL_WIDTH  scattered row data
- mem_valid  output  SIZE  per-lane write enable
- mem_req  output  1  row beat presented
- mem_ack  input  1  memory consumed the beat

Behaviour:
- Storage: two banks, each SIZE x SIZE pixels. Contents are not reset.
- State: wr_bank (1b), wr_col (clog2 SIZE), rd_bank (1b), rd_row (clog2 SIZE), full[1:0].
- Reset (rst_n=0 at a clk edge): all state cleared to 0. Outputs then read col_ready=1, mem_req=0, mem_data=0, mem_valid=0. A reset mid-bank discards partial and full banks.
- Accept condition: col_valid && col_ready, where col_ready = ~full[wr_bank].
- On accept:
  - tb[wr_bank][r][wr_col] <= col_pixels[r] for all r.
  - wr_col increments.
  - If wr_col==SIZE-1: wr_col wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Read side:
  - mem_req = full[rd_bank], combinational from registered state.
  - The first mem_req for a bank is asserted the cycle after its SIZE-th column is accepted (1-cycle latency).
- Row scatter (combinational):
  - Let k index the set bits of lane_mask in ascending lane order.
  - Lane at the k-th set bit gets row pixel k: tb[rd_bank][rd_row][k].
  - Unset lanes get data 0.
  - mem_valid = lane_mask & {SIZE{mem_req}}.
  - Pixels with index >= popcount(lane_mask) are not emitted.
  - lane_mask=0 still consumes a beat, with mem_valid=0.
- When mem_req=0: mem_data=0 and mem_valid=0, regardless of lane_mask.
- On mem_req && mem_ack:
  - rd_row increments.
  - If rd_row==SIZE-1: rd_row wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- mem_req may stay high across consecutive acked beats; throughput is one row per cycle.
- Simultaneous events:
  - Writing the final column of one bank while the final row of the other bank is acked updates both full bits in the same edge.
  - A bank freed on an edge accepts columns from the next cycle.
- Both banks full: col_ready=0; col_valid is ignored, with no overwrite.
- mem_ack without mem_req is ignored.

Optional Feature:
- Macro: TRANSPOSE_WRITER_FLUSH_EN
- Defined:
  - Adds input port flush (1b).
  - When flush=1 and wr_col!=0 (a partial bank), at the edge the current bank is closed: full set, wr_bank toggled, wr_col reset, and the per-bank column count stored.
  - On read, columns >= the stored count read as 0.
  - flush with wr_col==0 is ignored.
  - A flush coinciding with an accept includes that accepted column first.
- Undefined: no flush port; banks close only after SIZE columns.

Test Plan:
- Reset, then columns 0x1,0x2,0x4,0x8 accepted on consecutive cycles, lane_mask=0xF, mem_ack=1 -> mem_req rises the cycle after the 4th accept; rows out are 0x1,0x2,0x4,0x8 with mem_valid=0xF.
- Same fill with lane_mask=0xA and row 0 pixels {1,1,0,0} -> mem_data=0xA, mem_valid=0xA; lane_mask=0 -> mem_valid=0, handshake still advances rd_row.
- mem_ack held 0 while 8 columns are offered -> col_ready drops after the 8th accept; 9th column not written; after 4 acks col_ready=1 again.
- Back-to-back streaming: columns every cycle and mem_ack every cycle -> no stall after the first bank; the simultaneous full set/clear on the same edge is handled correctly.
- rst_n=0 after 2 columns -> next cycle col_ready=1, mem_req=0; a fresh 4-column fill produces correct rows with no stale state.
- With TRANSPOSE_WRITER_FLUSH_EN: 2 columns 0xF,0xF then flush -> rows read 0x3 each with lane_mask=0xF.
